// File: rtl/gf2_toom3_mul_seq_pkg.sv
// gf2_mul_pkg: shared split/digit helpers and FSM state type for the GF(2)[x] multipliers.
//   split_width(n)  : limb width K = ceil(n/3)
//   num_digits(k,d) : accumulate cycles S = ceil(k/d)
//   state_t         : IDLE / ACCUM / COMBINE
package gf2_mul_pkg;

    typedef enum logic [1:0] {IDLE, ACCUM, COMBINE} state_t;

    function automatic int split_width(input int n);
        return (n + 2) / 3;
    endfunction

    function automatic int num_digits(input int k, input int d);
        return (k + d - 1) / d;
    endfunction

endpackage

// File: rtl/gf2_toom3_mul_seq_if.sv
// gf2_toom3_mul_seq_if: start/valid request bus of the sequential GF(2)[x] multiplier.
//   start : request, accepted only while busy is low
//   a, b  : N-bit operand polynomials (bit i = coefficient of x^i)
//   busy  : core occupied
//   valid : one-cycle pulse, c carries a new product
//   c     : 2N-bit product
interface gf2_toom3_mul_seq_if #(parameter int N = 409);

    logic           start;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           busy;
    logic           valid;
    logic [2*N-1:0] c;

    modport master (output start, a, b, input busy, valid, c);
    modport slave  (input start, a, b, output busy, valid, c);

endinterface

// File: rtl/gf2_toom3_mul_seq_mac.sv
// gf2_digit_mac: XOR update of one K x K limb product for one multiplier digit.
//   i_a    : multiplicand limb (K bits)
//   i_b    : multiplier limb (K bits)
//   i_idx  : digit index; covers multiplier bits [i_idx*D, i_idx*D+D-1]
//   o_upd  : XOR of (i_a << j) over every set multiplier bit j of that digit
module gf2_digit_mac #(
    parameter int K  = 137,
    parameter int D  = 1,
    parameter int IW = 8
) (
    input  logic [K-1:0]   i_a,
    input  logic [K-1:0]   i_b,
    input  logic [IW-1:0]  i_idx,
    output logic [2*K-2:0] o_upd
);

    localparam int W = 2 * K - 1;

    logic [31:0]  w_base;
    logic [D-1:0] w_dig;

    // Shifting the limb right drops bits past K-1, so the last digit truncates itself.
    always_comb begin
        w_base = 32'(i_idx) * D;
        w_dig  = D'(i_b >> w_base);
        o_upd  = '0;
        for (int t = 0; t < D; t++)
            o_upd = o_upd ^ (w_dig[t] ? (W'(i_a) << (w_base + t)) : '0);
    end

endmodule

// File: rtl/gf2_toom3_mul_seq.sv
// gf2_toom3_mul_seq: sequential carry-less N x N multiplier, three-way split, digit-serial.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of gf2_toom3_mul_seq_if (start/a/b in, busy/valid/c out)
// Latency from accepted start to valid is ceil(ceil(N/3)/D) + 1 + PIPE cycles.
module gf2_toom3_mul_seq
    import gf2_mul_pkg::*;
#(
    parameter int N    = 409,
    parameter int D    = 1,
    parameter int PIPE = 2
) (
    input logic                  clk,
    input logic                  rst,
    gf2_toom3_mul_seq_if.slave   bus
);

    localparam int K  = split_width(N);
    localparam int S  = num_digits(K, D);
    localparam int IW = $clog2(S + 1);
    localparam int W  = 2 * K - 1;
    localparam int T  = 3 * K;
    localparam int R  = 2 * N;

    state_t        r_state;
    logic [IW-1:0] r_cnt;
    logic          r_busy;
    logic          r_valid;
    logic [R-1:0]  r_c;
    logic [T-1:0]  r_a;
    logic [T-1:0]  r_b;
    logic [W-1:0]  r_p   [3][3];
    logic [W-1:0]  w_upd [3][3];
    logic [T-1:0]  w_ax;
    logic [T-1:0]  w_bx;
    logic          w_v   [PIPE+1];
    logic [R-1:0]  w_d   [PIPE+1];

    // Zero-extension to 3K gives the high limb its padding for free.
    assign w_ax = T'(bus.a);
    assign w_bx = T'(bus.b);

    // r_p[i][j] accumulates a_i * b_j; all nine share r_cnt so they stay in step.
    for (genvar i = 0; i < 3; i++) begin : g_a
        for (genvar j = 0; j < 3; j++) begin : g_b
            gf2_digit_mac #(.K(K), .D(D), .IW(IW)) u_mac (
                .i_a   (r_a[i*K +: K]),
                .i_b   (r_b[j*K +: K]),
                .i_idx (r_cnt),
                .o_upd (w_upd[i][j])
            );
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            for (int x = 0; x < 3; x++)
                for (int y = 0; y < 3; y++)
                    r_p[x][y] <= '0;
        end else begin
            case (r_state)
                IDLE: if (bus.start) begin
                    r_state <= ACCUM;
                    r_busy  <= 1'b1;
                    r_cnt   <= '0;
                    r_a     <= w_ax;
                    r_b     <= w_bx;
                    for (int x = 0; x < 3; x++)
                        for (int y = 0; y < 3; y++)
                            r_p[x][y] <= '0;
                end
                ACCUM: begin
                    for (int x = 0; x < 3; x++)
                        for (int y = 0; y < 3; y++)
                            r_p[x][y] <= r_p[x][y] ^ w_upd[x][y];
                    r_cnt   <= r_cnt + 1'b1;
                    r_state <= (r_cnt == IW'(S - 1)) ? COMBINE : ACCUM;
                end
                COMBINE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // r = h ^ g<<K ^ f<<2K ^ e<<3K ^ d<<4K; widening to 2N first makes the shifts truncate.
    assign w_v[0] = (r_state == COMBINE);
    assign w_d[0] = R'(r_p[0][0])
                  ^ (R'(r_p[0][1] ^ r_p[1][0]) << K)
                  ^ (R'(r_p[0][2] ^ r_p[1][1] ^ r_p[2][0]) << (2 * K))
                  ^ (R'(r_p[1][2] ^ r_p[2][1]) << (3 * K))
                  ^ (R'(r_p[2][2]) << (4 * K));

    for (genvar p = 0; p < PIPE; p++) begin : g_pipe
        logic         r_v;
        logic [R-1:0] r_d;
        always_ff @(posedge clk) begin
            if (rst) begin
                r_v <= 1'b0;
                r_d <= '0;
            end else begin
                r_v <= w_v[p];
                r_d <= w_d[p];
            end
        end
        assign w_v[p+1] = r_v;
        assign w_d[p+1] = r_d;
    end

    // c only moves on a valid token, so it holds the last product between results.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_c     <= '0;
        end else begin
            r_valid <= w_v[PIPE];
            if (w_v[PIPE])
                r_c <= w_d[PIPE];
        end
    end

    assign bus.busy  = r_busy;
    assign bus.valid = r_valid;
    assign bus.c     = r_c;

endmodule
